// File: rtl/dual_stream_merge.sv
// Merges a registered and a pass-through valid-only stream into one valid/ready stream with a source tag.
// Define DUAL_STREAM_MERGE_FIXED_PRIO_EN for fixed reg-first priority instead of round-robin.
module dual_stream_merge #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_reg_data,
    input  logic                   in_reg_valid,
    input  logic [WIDTH-1:0]       in_wire_data,
    input  logic                   in_wire_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] reg_fill,
    output logic [$clog2(DEPTH):0] wire_fill,
    output logic [1:0]             overflow,
    input  logic                   overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Channel index 0 = reg, 1 = wire, matching the out_src encoding.
    logic [CW-1:0]    cnt     [2];
    logic [AW-1:0]    wr_ptr  [2];
    logic [AW-1:0]    rd_ptr  [2];
    logic [WIDTH-1:0] head    [2];
    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       in_valid, nonempty, push, pop, drop;
    logic             sel, load;
`ifndef DUAL_STREAM_MERGE_FIXED_PRIO_EN
    logic             last_src;
`endif

    assign in_valid    = {in_wire_valid, in_reg_valid};
    assign in_data[0]  = in_reg_data;
    assign in_data[1]  = in_wire_data;
    assign nonempty[0] = (cnt[0] != '0);
    assign nonempty[1] = (cnt[1] != '0);
    assign reg_fill    = cnt[0];
    assign wire_fill   = cnt[1];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        pop  = '0;
        push = '0;
        drop = '0;
`ifdef DUAL_STREAM_MERGE_FIXED_PRIO_EN
        sel  = ~nonempty[0];
`else
        sel  = nonempty[0] ? (nonempty[1] & ~last_src) : 1'b1;
`endif
        load = ~out_valid | out_ready;
        if (load && nonempty[sel]) pop[sel] = 1'b1;
        // A full FIFO still accepts when it pops on the same edge.
        push[0] = in_valid[0] & ((cnt[0] != FULL) | pop[0]);
        push[1] = in_valid[1] & ((cnt[1] != FULL) | pop[1]);
        drop    = in_valid & ~push;
    end

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];

        // NOTE: storage carries no reset; pointers and counts alone define what is valid.
        always_ff @(posedge clk) begin
            if (push[c]) mem[wr_ptr[c]] <= in_data[c];
        end

        assign head[c] = mem[rd_ptr[c]];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt[c]    <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end else begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
                case ({push[c], pop[c]})
                    2'b10:   cnt[c] <= cnt[c] + CW'(1);
                    2'b01:   cnt[c] <= cnt[c] - CW'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            overflow  <= 2'b00;
`ifndef DUAL_STREAM_MERGE_FIXED_PRIO_EN
            last_src  <= 1'b1;
`endif
        end else begin
            if (load) begin
                out_valid <= |pop;
                if (|pop) begin
                    out_data <= head[sel];
                    out_src  <= sel;
                end
            end
            // Clear first, then OR in this edge's drops so a coincident drop is kept.
            overflow <= (overflow_clr ? 2'b00 : overflow) | drop;
`ifndef DUAL_STREAM_MERGE_FIXED_PRIO_EN
            if (|pop) last_src <= sel;
`endif
        end
    end

endmodule

// File: tb/tb_dual_stream_merge.sv
// Directed bench for dual_stream_merge: queue-level reference model checked every cycle plus literal checkpoints.
module tb_dual_stream_merge;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_reg_data, in_wire_data, out_data;
    logic             in_reg_valid, in_wire_valid, out_valid, out_src, out_ready, overflow_clr;
    logic [2:0]       reg_fill, wire_fill;
    logic [1:0]       overflow;

    int tests = 0;
    int fails = 0;

    dual_stream_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_reg_data(in_reg_data), .in_reg_valid(in_reg_valid),
        .in_wire_data(in_wire_data), .in_wire_valid(in_wire_valid),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
        .reg_fill(reg_fill), .wire_fill(wire_fill),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, an output slot and the round-robin memory.
    logic [WIDTH-1:0] q_reg[$];
    logic [WIDTH-1:0] q_wire[$];
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_src   = 1'b0;
    logic [1:0]       m_ovf   = 2'b00;
    logic             m_last  = 1'b1;
    int               sz_reg, sz_wire, pick;
    logic [1:0]       popped;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg.delete();
            q_wire.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 1'b0;
            m_ovf   = 2'b00;
            m_last  = 1'b1;
        end else begin
            sz_reg  = q_reg.size();
            sz_wire = q_wire.size();
            popped  = 2'b00;
            if (!m_valid || out_ready) begin
                pick = -1;
`ifdef DUAL_STREAM_MERGE_FIXED_PRIO_EN
                if (sz_reg > 0)       pick = 0;
                else if (sz_wire > 0) pick = 1;
`else
                if (sz_reg > 0 && sz_wire > 0) pick = m_last ? 0 : 1;
                else if (sz_reg > 0)           pick = 0;
                else if (sz_wire > 0)          pick = 1;
`endif
                if (pick == 0) begin
                    m_data = q_reg.pop_front();
                end else if (pick == 1) begin
                    m_data = q_wire.pop_front();
                end
                m_valid = (pick >= 0);
                if (pick >= 0) begin
                    m_src  = (pick == 1);
                    m_last = (pick == 1);
                    popped[pick] = 1'b1;
                end
            end
            if (overflow_clr) m_ovf = 2'b00;
            if (in_reg_valid) begin
                if (sz_reg < DEPTH || popped[0]) q_reg.push_back(in_reg_data);
                else m_ovf[0] = 1'b1;
            end
            if (in_wire_valid) begin
                if (sz_wire < DEPTH || popped[1]) q_wire.push_back(in_wire_data);
                else m_ovf[1] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
        check("cmp_reg_fill", 32'(reg_fill), q_reg.size());
        check("cmp_wire_fill", 32'(wire_fill), q_wire.size());
        check("cmp_overflow", 32'(overflow), 32'(m_ovf));
        if (m_valid) begin
            check("cmp_out_data", 32'(out_data), 32'(m_data));
            check("cmp_out_src", 32'(out_src), 32'(m_src));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

`ifdef DUAL_STREAM_MERGE_FIXED_PRIO_EN
    logic [7:0] exp_order[6] = '{8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23};
    logic       exp_src[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    logic [7:0] exp_order[6] = '{8'd11, 8'd21, 8'd12, 8'd22, 8'd13, 8'd23};
    logic       exp_src[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    initial begin
        reset = 1'b0;
        in_reg_data = '0; in_reg_valid = 1'b0;
        in_wire_data = '0; in_wire_valid = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_fills", 32'({reg_fill, wire_fill}), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Single-word latency
        out_ready = 1'b1;
        in_reg_valid = 1'b1; in_reg_data = 8'hA5;
        cyc();
        in_reg_valid = 1'b0;
        check("lat_fill_after_write", 32'(reg_fill), 1);
        check("lat_not_yet_valid", 32'(out_valid), 0);
        cyc();
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'h A5);
        check("lat_src", 32'(out_src), 0);
        check("lat_fill_drained", 32'(reg_fill), 0);
        cyc();
        check("lat_consumed", 32'(out_valid), 0);

        // Arbitration order from preloaded FIFOs
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_reg_valid = 1'b1;  in_reg_data  = 8'(11 + i);
            in_wire_valid = 1'b1; in_wire_data = 8'(21 + i);
            cyc();
        end
        in_reg_valid = 1'b0; in_wire_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("arb_valid", 32'(out_valid), 1);
            check("arb_data", 32'(out_data), 32'(exp_order[i]));
            check("arb_src", 32'(out_src), 32'(exp_src[i]));
            cyc();
        end
        check("arb_empty", 32'(out_valid), 0);

        // Back-pressure hold while inputs keep arriving
        out_ready = 1'b0;
        in_reg_valid = 1'b1; in_reg_data = 8'h3C;
        cyc();
        in_reg_valid = 1'b0;
        cyc();
        check("hold_loaded", 32'(out_data), 32'h3C);
        for (int k = 0; k < 5; k++) begin
            in_reg_valid = 1'b1;  in_reg_data  = 8'(8'h50 + k);
            in_wire_valid = 1'b1; in_wire_data = 8'(8'h40 + k);
            cyc();
            check("hold_data", 32'(out_data), 32'h3C);
            check("hold_src", 32'(out_src), 0);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_fill_bound", 32'(reg_fill <= 3'(DEPTH) && wire_fill <= 3'(DEPTH)), 1);
        end
        in_reg_valid = 1'b0; in_wire_valid = 1'b0;
        check("hold_fills_full", 32'({reg_fill, wire_fill}), 32'({3'd4, 3'd4}));
        check("hold_overflow_both", 32'(overflow), 32'b11);
        out_ready = 1'b1; overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        check("hold_overflow_cleared", 32'(overflow), 0);
        repeat (10) cyc();
        check("hold_drained", 32'(out_valid), 0);

        // Overflow on the wire channel
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_wire_valid = 1'b1; in_wire_data = 8'(8'h60 + k);
            cyc();
        end
        in_wire_valid = 1'b0;
        check("ovf_flag", 32'(overflow), 32'b10);
        check("ovf_wire_fill", 32'(wire_fill), 4);
        check("ovf_out_data", 32'(out_data), 32'h60);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full FIFO accepting a write on the edge it pops
        out_ready = 1'b1; in_wire_valid = 1'b1; in_wire_data = 8'h66;
        cyc();
        out_ready = 1'b0; in_wire_valid = 1'b0;
        check("fullpop_fill", 32'(wire_fill), 4);
        check("fullpop_overflow", 32'(overflow), 0);
        check("fullpop_out_data", 32'(out_data), 32'h61);

        // Drop coincident with clear: the set wins
        in_wire_valid = 1'b1; in_wire_data = 8'h67; overflow_clr = 1'b1;
        cyc();
        in_wire_valid = 1'b0; overflow_clr = 1'b0;
        check("setwins_overflow", 32'(overflow), 32'b10);

        // Asynchronous reset between edges
        in_reg_valid = 1'b1; in_reg_data = 8'h70;
        cyc();
        in_reg_valid = 1'b0;
        check("areset_pre_fills", 32'({reg_fill, wire_fill}), 32'({3'd1, 3'd4}));
        check("areset_pre_valid", 32'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 0);
        check("areset_fills", 32'({reg_fill, wire_fill}), 0);
        check("areset_overflow", 32'(overflow), 0);
        cyc();
        cyc();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            cyc();
            check("areset_no_stale", 32'(out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
